seq_multdiv: RTL and testbench

Parametrised iterative multiply/divide unit for the execute stage of the pipelined core, replacing the fixed 32-bit multiplier/divider. It accepts one operation per start pulse, computes one result bit per cycle for any operand width, and supports signed and unsigned modes. It also produces a full double-width product or a quotient/remainder pair, and accepts a cancel for pipeline flushes. The execute stage holds the pipeline while `busy` is high and consumes the result on `result_valid`.

---
 rtl/seq_multdiv.sv | 174 +++++++++++++++++
 tb/tb_seq_multdiv.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_multdiv.sv
// seq_multdiv: iterative multiply/divide unit that produces one result bit per cycle.
//   Multiply uses shift-add into a double-width accumulator. Divide uses restoring
//   division. Signed operations are done on magnitudes, and the sign is fixed up
//   when the operation completes.
// Ports:
//   clock, reset       rising-edge clock; synchronous active-high reset
//   start, op          request; op = 00 MULT, 01 DIV, 10 MULTU, 11 DIVU
//   operand_a/b        multiplicand/dividend, multiplier/divisor (latched at start)
//   cancel             abort an in-flight operation; also drops a same-cycle start
//   busy               high while RUN
//   result_valid       one-cycle pulse while DONE
//   result, result_hi  low/high product, or quotient/remainder
//   exception          overflow or divide-by-zero
module seq_multdiv #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             cancel,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             exception
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_next;
  logic load, step_en, finish;

  logic [CW-1:0]      cnt;
  logic               is_div, is_signed, neg_res, neg_dvd;
  logic [WIDTH-1:0]   b_mag;
  // Upper half holds the partial product (multiply) or the partial remainder (divide).
  // Lower half holds the remaining multiplier bits, or dividend bits shifting out
  // while quotient bits shift in.
  logic [2*WIDTH-1:0] acc, acc_step;

  logic               in_signed;
  logic [WIDTH-1:0]   a_in_mag, b_in_mag;
  logic [WIDTH:0]     mul_sum, rem_sh, diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, fin_lo, fin_hi;
  logic               fin_exc;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step_en    = 1'b0;
    finish     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !cancel) begin
          state_next = RUN;
          load       = 1'b1;
        end
      end
      RUN: begin
        if (cancel) begin
          state_next = IDLE;
        end else begin
          step_en = 1'b1;
          if (cnt == LAST) begin
            state_next = DONE;
            finish     = 1'b1;
          end
        end
      end
      DONE: begin
        if (start && !cancel) begin
          state_next = RUN;
          load       = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy         = (state == RUN);
  assign result_valid = (state == DONE);

  // Convert the operands to magnitudes. The most-negative value stays 100..0, which is
  // already the correct unsigned magnitude.
  always_comb begin
    in_signed = ~op[1];
    a_in_mag  = (in_signed && operand_a[WIDTH-1]) ? -operand_a : operand_a;
    b_in_mag  = (in_signed && operand_b[WIDTH-1]) ? -operand_b : operand_b;
  end

  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_mag} : '0);
    rem_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff    = rem_sh - {1'b0, b_mag};
    if (is_div) begin
      if (diff[WIDTH]) acc_step = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else             acc_step = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  // Final fix-up is applied to the last step's value so that it lands in the
  // output registers on the RUN->DONE edge.
  always_comb begin
    prod    = neg_res ? -acc_step : acc_step;
    quo     = acc_step[WIDTH-1:0];
    rem     = acc_step[2*WIDTH-1:WIDTH];
    fin_lo  = '0;
    fin_hi  = '0;
    fin_exc = 1'b0;
    if (!is_div) begin
      fin_lo  = prod[WIDTH-1:0];
      fin_hi  = prod[2*WIDTH-1:WIDTH];
      fin_exc = is_signed ? (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}})
                          : (prod[2*WIDTH-1:WIDTH] != '0);
    end else if (b_mag == '0) begin
      fin_exc = 1'b1;
    end else begin
      fin_lo  = neg_res ? -quo : quo;
      fin_hi  = neg_dvd ? -rem : rem;
      // A positive-signed quotient with its top bit set can only come from MIN / -1.
      fin_exc = is_signed && !neg_res && quo[WIDTH-1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt       <= '0;
      acc       <= '0;
      b_mag     <= '0;
      is_div    <= 1'b0;
      is_signed <= 1'b0;
      neg_res   <= 1'b0;
      neg_dvd   <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      exception <= 1'b0;
    end else begin
      if (load) begin
        is_div    <= op[0];
        is_signed <= in_signed;
        neg_res   <= in_signed & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
        neg_dvd   <= in_signed & operand_a[WIDTH-1];
        b_mag     <= b_in_mag;
        acc       <= {{WIDTH{1'b0}}, a_in_mag};
        cnt       <= '0;
      end else if (step_en) begin
        acc <= acc_step;
        cnt <= cnt + CW'(1);
      end
      if (finish) begin
        result    <= fin_lo;
        result_hi <= fin_hi;
        exception <= fin_exc;
      end
    end
  end

endmodule

// File: tb/tb_seq_multdiv.sv
// tb_seq_multdiv: self-checking bench for seq_multdiv. It instantiates one unit with
//   WIDTH=32 and one with WIDTH=8. Expected results are pushed to per-unit queues when
//   an operation is issued, and are popped and compared when result_valid is seen.
module tb_seq_multdiv;

  localparam logic [1:0] MULT = 2'b00, DIV = 2'b01, MULTU = 2'b10, DIVU = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  logic        rst32, start32, cancel32, busy32, rv32, exc32;
  logic [1:0]  op32;
  logic [31:0] a32, b32, res32, hi32;
  logic        rst8, start8, cancel8, busy8, rv8, exc8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, res8, hi8;

  seq_multdiv #(.WIDTH(32)) dut32 (
    .clock(clk), .reset(rst32), .start(start32), .op(op32),
    .operand_a(a32), .operand_b(b32), .cancel(cancel32),
    .busy(busy32), .result_valid(rv32), .result(res32),
    .result_hi(hi32), .exception(exc32)
  );

  seq_multdiv #(.WIDTH(8)) dut8 (
    .clock(clk), .reset(rst8), .start(start8), .op(op8),
    .operand_a(a8), .operand_b(b8), .cancel(cancel8),
    .busy(busy8), .result_valid(rv8), .result(res8),
    .result_hi(hi8), .exception(exc8)
  );

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        exc;
    int          sc;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        exc;
  } vec_t;

  exp_t q32[$];
  exp_t q8[$];
  exp_t last32, m32, m8;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=0x%h required=0x%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model built on native wide arithmetic, for any width up to 32.
  function automatic exp_t model(input int w, input logic [1:0] o,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    longint mask, half, ua, ub, sa, sb, p, q, m;
    longint unsigned uau, ubu, pu;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua = longint'({32'd0, a}) & mask;
    ub = longint'({32'd0, b}) & mask;
    sa = (ua >= half) ? ua - (mask + 1) : ua;
    sb = (ub >= half) ? ub - (mask + 1) : ub;
    r.lo = '0; r.hi = '0; r.exc = 1'b0; r.sc = 0;
    if (!o[0]) begin
      if (!o[1]) begin
        p     = sa * sb;
        r.lo  = 32'(p & mask);
        r.hi  = 32'((p >>> w) & mask);
        r.exc = (p < -half) || (p >= half);
      end else begin
        uau   = ua;
        ubu   = ub;
        pu    = uau * ubu;
        r.lo  = 32'(pu & mask);
        r.hi  = 32'((pu >> w) & mask);
        r.exc = (pu >> w) != 0;
      end
    end else if (ub == 0) begin
      r.exc = 1'b1;
    end else if (!o[1] && sa == -half && sb == -1) begin
      r.lo  = 32'(half);
      r.exc = 1'b1;
    end else if (!o[1]) begin
      q = sa / sb;
      m = sa % sb;
      r.lo = 32'(q & mask);
      r.hi = 32'(m & mask);
    end else begin
      q = ua / ub;
      m = ua % ub;
      r.lo = 32'(q & mask);
      r.hi = 32'(m & mask);
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (rv32 === 1'b1) begin
      if (q32.size() == 0) begin
        total++; bad++;
        $display("FAIL valid32_unexpected actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        m32 = q32.pop_front();
        chk("result32", res32, m32.lo);
        chk("result_hi32", hi32, m32.hi);
        chk("exception32", 32'(exc32), 32'(m32.exc));
        chk("latency32", 32'(cyc - m32.sc), 32'd32);
        last32 = m32;
      end
    end
    if (rv8 === 1'b1) begin
      if (q8.size() == 0) begin
        total++; bad++;
        $display("FAIL valid8_unexpected actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        m8 = q8.pop_front();
        chk("result8", 32'(res8), m8.lo);
        chk("result_hi8", 32'(hi8), m8.hi);
        chk("exception8", 32'(exc8), 32'(m8.exc));
        chk("latency8", 32'(cyc - m8.sc), 32'd8);
      end
    end
  end

  task automatic issue32(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit track, input exp_t e);
    op32 = o; a32 = a; b32 = b; start32 = 1'b1;
    if (track) begin
      e.sc = cyc + 1;
      q32.push_back(e);
    end
    tick();
    start32 = 1'b0;
    op32 = 2'($urandom);
    a32 = $urandom;
    b32 = $urandom;
  endtask

  task automatic issue8(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                        input bit track, input exp_t e);
    op8 = o; a8 = a; b8 = b; start8 = 1'b1;
    if (track) begin
      e.sc = cyc + 1;
      q8.push_back(e);
    end
    tick();
    start8 = 1'b0;
    op8 = 2'($urandom);
    a8 = 8'($urandom);
    b8 = 8'($urandom);
  endtask

  task automatic wait_done32();
    int n = 0;
    while (q32.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    if (q32.size() != 0) begin
      total++; bad++;
      $display("FAIL timeout32 actual=no_valid required=valid_within_60_cycles");
      q32.delete();
    end
  endtask

  task automatic wait_done8();
    int n = 0;
    while (q8.size() != 0 && n < 30) begin
      tick();
      n++;
    end
    if (q8.size() != 0) begin
      total++; bad++;
      $display("FAIL timeout8 actual=no_valid required=valid_within_30_cycles");
      q8.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[14];
    exp_t e;
    logic [1:0] ro;
    logic [31:0] ra, rb;

    tbl[0]  = '{MULT,  32'hFFFFFFF9, 32'd6,        32'hFFFFFFD6, 32'hFFFFFFFF, 1'b0};
    tbl[1]  = '{MULT,  32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001, 1'b1};
    tbl[2]  = '{MULTU, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001, 1'b1};
    tbl[3]  = '{DIV,   32'hFFFFFFEF, 32'd5,        32'hFFFFFFFD, 32'hFFFFFFFE, 1'b0};
    tbl[4]  = '{DIVU,  32'd17,       32'd5,        32'd3,        32'd2,        1'b0};
    tbl[5]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b1};
    tbl[6]  = '{DIV,   32'd42,       32'd0,        32'd0,        32'd0,        1'b1};
    tbl[7]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b1};
    tbl[8]  = '{MULT,  32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 1'b1};
    tbl[9]  = '{DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 32'h0000000F, 1'b0};
    tbl[10] = '{DIV,   32'd17,       32'hFFFFFFFB, 32'hFFFFFFFD, 32'd2,        1'b0};
    tbl[11] = '{DIVU,  32'd5,        32'd0,        32'd0,        32'd0,        1'b1};
    tbl[12] = '{DIV,   32'h80000000, 32'd1,        32'h80000000, 32'd0,        1'b0};
    tbl[13] = '{MULT,  32'd7,        32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0};

    rst32 = 1'b1; start32 = 1'b0; cancel32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
    rst8  = 1'b1; start8  = 1'b0; cancel8  = 1'b0; op8  = '0; a8  = '0; b8  = '0;
    repeat (3) tick();

    chk("reset_busy32", 32'(busy32), 32'd0);
    chk("reset_valid32", 32'(rv32), 32'd0);
    chk("reset_result32", res32, 32'd0);
    chk("reset_hi32", hi32, 32'd0);
    chk("reset_exc32", 32'(exc32), 32'd0);
    chk("reset_busy8", 32'(busy8), 32'd0);
    chk("reset_valid8", 32'(rv8), 32'd0);
    chk("reset_result8", 32'(res8), 32'd0);
    chk("reset_hi8", 32'(hi8), 32'd0);
    chk("reset_exc8", 32'(exc8), 32'd0);
    rst32 = 1'b0;
    rst8  = 1'b0;
    tick();

    for (int i = 0; i < 14; i++) begin
      e = '{tbl[i].lo, tbl[i].hi, tbl[i].exc, 0};
      issue32(tbl[i].op, tbl[i].a, tbl[i].b, 1'b1, e);
      chk("busy32_after_start", 32'(busy32), 32'd1);
      wait_done32();
    end

    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom);
      ra = $urandom;
      rb = $urandom;
      if (ro[0] && i[0]) rb = rb >> 20;
      if (i == 5) rb = '0;
      e = model(32, ro, ra, rb);
      issue32(ro, ra, rb, 1'b1, e);
      wait_done32();
    end

    // A start while busy must be ignored; the first operation completes unchanged.
    e = model(32, MULT, 32'hFFFFFFF9, 32'd6);
    issue32(MULT, 32'hFFFFFFF9, 32'd6, 1'b1, e);
    repeat (9) tick();
    op32 = DIVU; a32 = 32'd1; b32 = 32'd1; start32 = 1'b1;
    tick();
    start32 = 1'b0;
    chk("busy32_midrun_start", 32'(busy32), 32'd1);
    wait_done32();
    repeat (3) tick();

    // Cancel in the final RUN cycle after a mid-run start attempt.
    issue32(MULT, 32'd3, 32'd5, 1'b0, e);
    repeat (10) tick();
    start32 = 1'b1;
    tick();
    start32 = 1'b0;
    repeat (20) tick();
    chk("busy32_final_step", 32'(busy32), 32'd1);
    cancel32 = 1'b1;
    tick();
    cancel32 = 1'b0;
    chk("cancel_busy32", 32'(busy32), 32'd0);
    chk("cancel_valid32", 32'(rv32), 32'd0);
    chk("cancel_hold_result32", res32, last32.lo);
    chk("cancel_hold_hi32", hi32, last32.hi);
    chk("cancel_hold_exc32", 32'(exc32), 32'(last32.exc));
    repeat (3) tick();
    chk("cancel_still_idle32", 32'(busy32), 32'd0);

    // Simultaneous start and cancel in IDLE: the start is dropped.
    op32 = MULT; a32 = 32'd2; b32 = 32'd2; start32 = 1'b1; cancel32 = 1'b1;
    tick();
    start32 = 1'b0; cancel32 = 1'b0;
    chk("start_cancel_busy32", 32'(busy32), 32'd0);
    tick();
    chk("start_cancel_valid32", 32'(rv32), 32'd0);

    // WIDTH=8: back-to-back operation started in the DONE cycle.
    e = '{32'h40, 32'h9C, 1'b1, 0};
    issue8(MULTU, 8'd200, 8'd200, 1'b1, e);
    repeat (8) tick();
    chk("valid8_done_cycle", 32'(rv8), 32'd1);
    e = model(8, DIV, 32'h9C, 32'h07);
    issue8(DIV, 8'h9C, 8'h07, 1'b1, e);
    chk("busy8_back_to_back", 32'(busy8), 32'd1);
    wait_done8();
    repeat (2) tick();

    // Reset while RUN clears every output.
    issue8(MULTU, 8'd15, 8'd15, 1'b0, e);
    repeat (4) tick();
    rst8 = 1'b1;
    tick();
    chk("midreset_busy8", 32'(busy8), 32'd0);
    chk("midreset_valid8", 32'(rv8), 32'd0);
    chk("midreset_result8", 32'(res8), 32'd0);
    chk("midreset_hi8", 32'(hi8), 32'd0);
    chk("midreset_exc8", 32'(exc8), 32'd0);
    rst8 = 1'b0;
    repeat (12) tick();
    chk("postreset_valid8", 32'(rv8), 32'd0);

    e = model(8, DIVU, 32'd250, 32'd7);
    issue8(DIVU, 8'd250, 8'd7, 1'b1, e);
    wait_done8();
    e = model(8, DIV, 32'h80, 32'hFF);
    issue8(DIV, 8'h80, 8'hFF, 1'b1, e);
    wait_done8();
    e = model(8, DIVU, 32'd9, 32'd0);
    issue8(DIVU, 8'd9, 8'd0, 1'b1, e);
    wait_done8();
    e = model(8, MULT, 32'h81, 32'h03);
    issue8(MULT, 8'h81, 8'h03, 1'b1, e);
    wait_done8();
    repeat (3) tick();

    chk("queue32_drained", 32'(q32.size()), 32'd0);
    chk("queue8_drained", 32'(q8.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
